// File: rtl/pcs_gmii_pkg.sv
// Shared GMII transmit definitions: generator FSM states, control-byte constants, PRBS8 step.
// No latency or backpressure of its own; consumed by gmii_frame_gen and gmii_payload_lfsr.
package pcs_gmii_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_PAY,
      ST_IPG
   } gen_state_t;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam logic [2:0] XMIT_DATA     = 3'b010;
   // feedback = b[7]^b[5]^b[4]^b[3], shifted in at the LSB
   localparam logic [7:0] PRBS8_TAPS    = 8'hB8;

   function automatic logic [7:0] prbs8_next(input logic [7:0] b);
      return {b[6:0], ^(b & PRBS8_TAPS)};
   endfunction

endpackage

// File: rtl/gmii_payload_lfsr.sv
// Payload byte source: load takes the seed, advance steps incrementing or PRBS8 sequence.
// Output is the registered current byte, updated one cycle after load/advance; no backpressure.
module gmii_payload_lfsr
   import pcs_gmii_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode,
   input  logic [7:0] seed,
   input  logic       load,
   input  logic       advance,
   output logic [7:0] dat
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dat <= 8'h00;
      end else if (load) begin
         // an all-zero PRBS register would lock up, so seed 0 starts at 8'h01
         dat <= (mode && seed == 8'h00) ? 8'h01 : seed;
      end else if (advance) begin
         dat <= mode ? prbs8_next(dat) : dat + 8'd1;
      end
   end

endmodule

// File: rtl/gmii_frame_gen.sv
// GMII frame generator (preamble, SFD, payload, IPG) with TX_ER injection under GMII_ERR_INJECT_EN.
// All outputs registered; first preamble byte one cycle after start; no backpressure on the GMII side.
module gmii_frame_gen
   import pcs_gmii_pkg::*;
#(
   parameter int PREAMBLE_LEN = 7,
   parameter int IPG_LEN      = 12,
   parameter int LEN_W        = 11,
   parameter int CNT_W        = 8
)
(
   input  logic             GTX_CLK,
   input  logic             mr_main_reset,
   input  logic [2:0]       xmit,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [7:0]       seed,
   input  logic [LEN_W-1:0] payload_len,
   input  logic [CNT_W-1:0] num_frames,
   input  logic             err_en,
   input  logic [LEN_W-1:0] err_pos,
   output logic [7:0]       TXD,
   output logic             TX_EN,
   output logic             TX_ER,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] frames_sent
);

   localparam int CW = $clog2((PREAMBLE_LEN > IPG_LEN ? PREAMBLE_LEN : IPG_LEN) + 1);

   gen_state_t       state;
   logic [CW-1:0]    cnt;
   logic [LEN_W-1:0] idx;
   logic [LEN_W-1:0] nxt_idx;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] err_pos_q;
   logic [CNT_W-1:0] num_q;
   logic [7:0]       seed_q;
   logic             mode_q;
   logic             err_en_q;
   logic             stop_q;
   logic [7:0]       pay_dat;
   logic             end_burst;
   logic             hit_first;
   logic             hit_next;

   gmii_payload_lfsr u_lfsr (
      .clk     (GTX_CLK),
      .rst_n   (mr_main_reset),
      .mode    (mode_q),
      .seed    (seed_q),
      .load    (state == ST_PRE),
      .advance (state == ST_SFD || state == ST_PAY),
      .dat     (pay_dat)
   );

   assign nxt_idx   = idx + 1'b1;
   assign end_burst = stop_q || stop || (xmit != XMIT_DATA) ||
                      ((num_q != '0) && (frames_sent == num_q));

`ifdef GMII_ERR_INJECT_EN
   logic err_arm;
   assign err_arm   = err_en_q && (err_pos_q < len_q);
   assign hit_first = err_arm && (err_pos_q == '0);
   assign hit_next  = err_arm && (err_pos_q == nxt_idx);
`else
   logic unused_err;
   assign unused_err = err_en_q ^ (^err_pos_q);
   assign hit_first  = 1'b0;
   assign hit_next   = 1'b0;
`endif

   always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
      if (!mr_main_reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         idx         <= '0;
         len_q       <= '0;
         err_pos_q   <= '0;
         num_q       <= '0;
         seed_q      <= 8'h00;
         mode_q      <= 1'b0;
         err_en_q    <= 1'b0;
         stop_q      <= 1'b0;
         TXD         <= 8'h00;
         TX_EN       <= 1'b0;
         TX_ER       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         frames_sent <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && xmit == XMIT_DATA) begin
                  mode_q      <= mode;
                  seed_q      <= seed;
                  len_q       <= (payload_len == '0) ? LEN_W'(1) : payload_len;
                  num_q       <= num_frames;
                  err_en_q    <= err_en;
                  err_pos_q   <= err_pos;
                  stop_q      <= stop;
                  frames_sent <= '0;
                  cnt         <= CW'(1);
                  TXD         <= PREAMBLE_BYTE;
                  TX_EN       <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ST_PRE;
               end
            end
            ST_PRE: begin
               if (cnt == CW'(PREAMBLE_LEN)) begin
                  TXD   <= SFD_BYTE;
                  state <= ST_SFD;
               end else begin
                  cnt <= cnt + 1'b1;
                  TXD <= PREAMBLE_BYTE;
               end
            end
            ST_SFD: begin
               idx   <= '0;
               TXD   <= pay_dat;
               TX_ER <= hit_first;
               state <= ST_PAY;
            end
            ST_PAY: begin
               if (idx == len_q - 1'b1) begin
                  TXD   <= 8'h00;
                  TX_EN <= 1'b0;
                  TX_ER <= 1'b0;
                  cnt   <= CW'(1);
                  state <= ST_IPG;
                  if (frames_sent != '1)
                     frames_sent <= frames_sent + 1'b1;
               end else begin
                  idx   <= nxt_idx;
                  TXD   <= pay_dat;
                  TX_ER <= hit_next;
               end
            end
            ST_IPG: begin
               if (cnt == CW'(IPG_LEN)) begin
                  if (end_burst) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     cnt   <= CW'(1);
                     TXD   <= PREAMBLE_BYTE;
                     TX_EN <= 1'b1;
                     state <= ST_PRE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
         // a stop request (or loss of DATA mode) is remembered until the current frame's IPG ends
         if (state != ST_IDLE && (stop || xmit != XMIT_DATA))
            stop_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Directed bench for gmii_frame_gen: table of burst configurations with hand-computed payloads,
// plus reset, xmit gating and mid-frame reset sequences.
module tb_gmii_frame_gen;

   localparam int PRE  = 7;
   localparam int IPG  = 12;
   localparam int CMAX = 1023;
`ifdef GMII_ERR_INJECT_EN
   localparam bit ER_ON = 1'b1;
`else
   localparam bit ER_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  xmit = 3'b010;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        mode = 1'b0;
   logic [7:0]  seed = 8'h00;
   logic [10:0] payload_len = 11'd0;
   logic [7:0]  num_frames = 8'd0;
   logic        err_en = 1'b0;
   logic [10:0] err_pos = 11'd0;
   logic [7:0]  TXD;
   logic        TX_EN;
   logic        TX_ER;
   logic        busy;
   logic        done;
   logic [7:0]  frames_sent;

   gmii_frame_gen dut (
      .GTX_CLK       (clk),
      .mr_main_reset (rst_n),
      .xmit          (xmit),
      .start         (start),
      .stop          (stop),
      .mode          (mode),
      .seed          (seed),
      .payload_len   (payload_len),
      .num_frames    (num_frames),
      .err_en        (err_en),
      .err_pos       (err_pos),
      .TXD           (TXD),
      .TX_EN         (TX_EN),
      .TX_ER         (TX_ER),
      .busy          (busy),
      .done          (done),
      .frames_sent   (frames_sent)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            mode;
      logic [7:0]      seed;
      logic [10:0]     len;
      logic [7:0]      num;
      logic            err_en;
      logic [10:0]     err_pos;
      int              stop_at;   // capture cycle at which stop is raised; 0 = with start, -1 = never
      logic            stop_xmit; // raise "stop" by leaving DATA mode instead of the stop pin
      int              nfr;
      int              npay;
      logic [0:9][7:0] pay;
      int              er_idx;
   } vec_t;

   vec_t        tv [10];
   logic [10:0] cap [0:CMAX];
   logic [10:0] ex  [0:CMAX];
   int          n_chk = 0;
   int          n_bad = 0;

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic run_vec(input int vi, input vec_t v);
      int  ncap, nexp, nbad, first;
      int  er;
      bit  seen;
      mode = v.mode; seed = v.seed; payload_len = v.len; num_frames = v.num;
      err_en = v.err_en; err_pos = v.err_pos;
      @(negedge clk);
      start = 1'b1;
      if (v.stop_at == 0) stop = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ncap = 0; seen = 1'b0;
      while (!seen && ncap < CMAX) begin
         if (v.stop_at > 0 && ncap == v.stop_at) begin
            if (v.stop_xmit) xmit = 3'b001;
            else stop = 1'b1;
         end
         if (done) seen = 1'b1;
         else begin
            cap[ncap] = {busy, TX_EN, TX_ER, TXD};
            ncap++;
            @(negedge clk);
         end
      end
      check($sformatf("v%0d done_seen", vi), int'(seen), 1);
      er = ER_ON ? v.er_idx : -1;
      nexp = 0;
      for (int f = 0; f < v.nfr; f++) begin
         for (int i = 0; i < PRE; i++) begin ex[nexp] = {3'b110, 8'h55}; nexp++; end
         ex[nexp] = {3'b110, 8'hD5}; nexp++;
         for (int i = 0; i < v.npay; i++) begin
            ex[nexp] = {2'b11, (i == er), v.pay[i]}; nexp++;
         end
         for (int i = 0; i < IPG; i++) begin ex[nexp] = {3'b100, 8'h00}; nexp++; end
      end
      check($sformatf("v%0d cycles", vi), ncap, nexp);
      nbad = 0; first = -1;
      for (int i = 0; i < ncap && i < nexp; i++)
         if (cap[i] !== ex[i]) begin
            nbad++;
            if (first < 0) first = i;
         end
      n_chk++;
      if (nbad != 0) begin
         n_bad++;
         $display("FAIL v%0d stream: %0d bad cycles, first at %0d got {busy,en,er,txd}=%h expected %h",
                  vi, nbad, first, cap[first], ex[first]);
      end
      check($sformatf("v%0d frames_sent", vi), int'(frames_sent), v.nfr);
      check($sformatf("v%0d busy_at_done", vi), int'(busy), 0);
      @(negedge clk);
      check($sformatf("v%0d done_pulse_width", vi), int'(done), 0);
      stop = 1'b0;
      xmit = 3'b010;
   endtask

   initial begin
      int  hits;
      bit  seen;
      //            mode  seed   len  num eren epos stop_at sx  nfr npay payload bytes                                       er
      tv[0] = '{1'b0, 8'h01, 11'd10, 8'd1, 1'b1, 11'd2, -1, 1'b0, 1, 10,
                {8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09,8'h0A}, 2};
      tv[1] = '{1'b0, 8'hFE, 11'd4, 8'd1, 1'b0, 11'd1, -1, 1'b0, 1, 4,
                {8'hFE,8'hFF,8'h00,8'h01,48'h0}, -1};
      tv[2] = '{1'b0, 8'h33, 11'd0, 8'd1, 1'b0, 11'd0, -1, 1'b0, 1, 1,
                {8'h33,72'h0}, -1};
      tv[3] = '{1'b1, 8'h00, 11'd3, 8'd2, 1'b0, 11'd0, -1, 1'b0, 2, 3,
                {8'h01,8'h02,8'h04,56'h0}, -1};
      tv[4] = '{1'b1, 8'hB8, 11'd5, 8'd1, 1'b0, 11'd0, -1, 1'b0, 1, 5,
                {8'hB8,8'h70,8'hE0,8'hC0,8'h81,40'h0}, -1};
      tv[5] = '{1'b0, 8'h10, 11'd3, 8'd1, 1'b1, 11'd3, -1, 1'b0, 1, 3,
                {8'h10,8'h11,8'h12,56'h0}, -1};
      tv[6] = '{1'b0, 8'hA0, 11'd2, 8'd1, 1'b1, 11'd0, -1, 1'b0, 1, 2,
                {8'hA0,8'hA1,64'h0}, 0};
      // continuous: frame 3 payload occupies capture cycles 56..59
      tv[7] = '{1'b0, 8'h01, 11'd4, 8'd0, 1'b0, 11'd0, 57, 1'b0, 3, 4,
                {8'h01,8'h02,8'h03,8'h04,48'h0}, -1};
      tv[8] = '{1'b0, 8'h40, 11'd2, 8'd0, 1'b0, 11'd0, 0, 1'b0, 1, 2,
                {8'h40,8'h41,64'h0}, -1};
      tv[9] = '{1'b0, 8'h01, 11'd4, 8'd0, 1'b0, 11'd0, 10, 1'b1, 1, 4,
                {8'h01,8'h02,8'h03,8'h04,48'h0}, -1};

      repeat (3) @(negedge clk);
      check("rst TX_EN", int'(TX_EN), 0);
      check("rst busy", int'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst TXD", int'(TXD), 0);
      check("rst TX_ER", int'(TX_ER), 0);
      check("rst done", int'(done), 0);
      check("rst frames_sent", int'(frames_sent), 0);

      for (int i = 0; i < 10; i++) run_vec(i, tv[i]);

      // start outside DATA mode is ignored
      xmit = 3'b001; seed = 8'h01; payload_len = 11'd4; num_frames = 8'd1; err_en = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      hits = 0;
      for (int c = 0; c < 40; c++) begin
         if (busy || TX_EN) hits++;
         @(negedge clk);
      end
      check("xmit_gate activity", hits, 0);
      xmit = 3'b010;

      // asynchronous reset in the middle of the payload
      payload_len = 11'd10;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_reset TX_EN", int'(TX_EN), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst TX_EN", int'(TX_EN), 0);
      check("async_rst busy", int'(busy), 0);
      check("async_rst TXD", int'(TXD), 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("post_rst busy", int'(busy), 0);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("restart TX_EN", int'(TX_EN), 1);
      check("restart TXD", int'(TXD), 8'h55);
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      check("restart done_seen", int'(seen), 1);
      check("restart frames_sent", int'(frames_sent), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/gmii_frame_gen.md
# gmii_frame_gen

Synthesizable, parametrised GMII transmit traffic generator that drives the PCS transmit path (TXD/TX_EN/TX_ER) with complete Ethernet-style frames. Each frame is preamble, SFD, then payload; frames are separated by a programmable inter-frame gap. It supports a frame count, incrementing or PRBS payload, and optional TX_ER error injection. It replaces hand-timed stimulus and is usable both in benches and on hardware.

## Interface
- PREAMBLE_LEN, 7: number of 8'h55 preamble bytes (range 1..15).
- IPG_LEN, 12: idle cycles after each frame with TX_EN=0 (minimum 1).
- LEN_W, 11: width of payload length and error position.
- CNT_W, 8: width of the frame count and frames_sent.
- GTX_CLK  in  1  transmit clock; all logic on its rising edge.
- mr_main_reset  in  1  asynchronous, active-low reset.
- xmit  in  3  PCS transmit mode; start is accepted only when xmit==3'b010 (DATA).
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- stop  in  1  level; ends the burst after the current frame and its IPG.
- mode  in  1  payload mode: 0 = incrementing, 1 = PRBS8.
- seed  in  8  first payload byte / LFSR seed.
- payload_len  in  LEN_W  payload bytes per frame; a value of 0 is treated as 1.
- num_frames  in  CNT_W  frames per burst; 0 = continuous until stop.
- err_en  in  1  request TX_ER injection (active only with the macro).
- err_pos  in  LEN_W  payload index at which TX_ER is asserted.
- TXD  out  8  GMII data.
- TX_EN  out  1  GMII transmit enable.
- TX_ER  out  1  GMII transmit error.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the burst ends.
- frames_sent  out  CNT_W  frames completed since the last accepted start; saturates at its maximum value.

## Operation
- FSM states: IDLE, PRE, SFD, PAY, IPG.
- IDLE → PRE on start & xmit==3'b010.
  - Latch mode, seed, payload_len, num_frames, err_en, err_pos.
  - Clear frames_sent.
- PRE: TXD=8'h55, TX_EN=1, for PREAMBLE_LEN cycles, then SFD.
- SFD: TXD=8'hD5, TX_EN=1, one cycle, then PAY.
- PAY: TX_EN=1, one byte per cycle for the latched length, then IPG.
  - Incrementing mode: byte i = seed+i mod 256; wraps 8'hFF→8'h00.
  - PRBS mode: byte 0 = seed, with seed 0 replaced by 8'h01. Next byte = {b[6:0], b[7]^b[5]^b[4]^b[3]}.
  - The payload sequence restarts from seed on every frame.
- IPG: TXD=8'h00, TX_EN=0, TX_ER=0, for IPG_LEN cycles.
  - frames_sent increments on the first IPG cycle.
  - On the last IPG cycle, go to IDLE with a done pulse if stop is high or frames_sent==num_frames (num_frames≠0). Otherwise go to PRE.
- stop asserted during PRE/SFD/PAY: the current frame completes fully; it is never truncated.
- xmit leaving DATA mid-burst is treated as stop.
- start while busy is ignored.
- Simultaneous start and stop in IDLE: start wins. The burst then ends after one frame because stop is sampled in IPG.
- Reset mid-frame: outputs return to their reset values immediately, because the reset is asynchronous.

## Timing
- Reset values: TXD=8'h00, TX_EN=0, TX_ER=0, busy=0, done=0, frames_sent=0, FSM in IDLE.
- All outputs are registered.
- First preamble byte appears one cycle after the start edge.
- Frame length on TX_EN = PREAMBLE_LEN+1+payload_len cycles.
- Frame period = frame length + IPG_LEN.
- done is asserted in the cycle busy falls. A new start is accepted in the cycle after done.

## Configuration
- GMII_ERR_INJECT_EN defined:
  - If err_en and err_pos < latched payload length, TX_ER=1 for exactly the cycle that carries payload byte err_pos. TXD is unchanged in that cycle.
  - This applies in every frame of the burst.
- GMII_ERR_INJECT_EN undefined:
  - err_en and err_pos ports remain but are ignored.
  - TX_ER is constant 0.

## Structure
- Shared package pcs_gmii_pkg:
  - FSM state enum.
  - PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, XMIT_DATA 3'b010.
  - PRBS8 tap mask.
- One sub-module, gmii_payload_lfsr: 8-bit byte source with load/advance inputs and a mode select (increment vs PRBS8).

## Test plan
- Basic frame: PREAMBLE_LEN=7, seed=8'h01, mode=0, payload_len=10, num_frames=1 → TXD 55×7, D5, 01..0A; TX_EN high 18 cycles; 12 idle cycles; done pulse; frames_sent=1.
- Wrap and zero length: seed=8'hFE, payload_len=4 → payload FE, FF, 00, 01. Then payload_len=0 → a single payload byte.
- PRBS: mode=1, seed=8'h00, payload_len=3 → 01, 02, 04. The next frame again starts at 01.
- Continuous burst: num_frames=0, stop raised mid-payload of frame 3 → frame 3 completes, IPG runs, done pulses, frames_sent=3.
- Error injection (macro on): err_en=1, err_pos=2, payload 01..0A → TX_ER high only with TXD=03. With the macro off, TX_ER is always 0.
- Reset and xmit gating: start while xmit=3'b001 → no activity. mr_main_reset low mid-PAY → TX_EN=0 immediately; after release, FSM is in IDLE.
